// File: rtl/spi_fsm_pkg.sv
// Shared types and defaults for the SPI memory-slave control FSM.
package spi_fsm_pkg;

    localparam int FRAME_BITS_DEFAULT = 8;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        GET    = 4'd1,
        GOT    = 4'd2,
        READ1  = 4'd3,
        READ2  = 4'd4,
        READ3  = 4'd5,
        WRITE1 = 4'd6,
        WRITE2 = 4'd7,
        DONE   = 4'd8
    } state_t;

endpackage

// File: rtl/spi_fsm_bit_counter.sv
// Clear/enable up-counter with a terminal-count flag; clear wins over enable.
module bit_counter #(
    parameter int WIDTH    = 3,
    parameter int TERMINAL = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/spi_fsm.sv
// Control FSM for the SPI memory slave: address/RW frame, then a read-out or write-in byte.
module spi_fsm
    import spi_fsm_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
    input  logic s_clk,
    input  logic rst_n,
    input  logic CS,
    input  logic read_write,
    output logic miso_buff,
    output logic ad_we,
    output logic sr_we,
    output logic dm_we
);

    localparam int CNT_W = $clog2(FRAME_BITS);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count;
    logic             frame_end;
    logic             cnt_clear;
    logic             cnt_enable;

    always_ff @(posedge s_clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // CS high overrides every transition; invalid encodings fall back to IDLE.
    always_comb begin
        state_next = state;
        if (CS) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    state_next = GET;
                GET:     if (frame_end) state_next = GOT;
                GOT:     state_next = read_write ? READ1 : WRITE1;
                READ1:   state_next = READ2;
                READ2:   state_next = READ3;
                READ3:   if (frame_end) state_next = DONE;
                WRITE1:  if (frame_end) state_next = WRITE2;
                WRITE2:  state_next = DONE;
                DONE:    state_next = DONE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        miso_buff  = 1'b0;
        ad_we      = 1'b0;
        sr_we      = 1'b0;
        dm_we      = 1'b0;
        cnt_enable = 1'b0;
        case (state)
            GET:     cnt_enable = 1'b1;
            GOT:     ad_we      = 1'b1;
            READ2:   sr_we      = 1'b1;
            READ3:   begin
                miso_buff  = 1'b1;
                cnt_enable = 1'b1;
            end
            WRITE1:  cnt_enable = 1'b1;
            WRITE2:  dm_we      = 1'b1;
            default: ;
        endcase
    end

    // Every state entry starts the bit count from zero.
    assign cnt_clear = CS || (state_next != state);

    bit_counter #(
        .WIDTH    (CNT_W),
        .TERMINAL (FRAME_BITS - 1)
    ) u_bit_counter (
        .clk    (s_clk),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .enable (cnt_enable),
        .count  (count),
        .tc     (frame_end)
    );

endmodule

// File: tb/tb_spi_fsm.sv
// Scoreboard bench for spi_fsm: stimulus queues per-edge expected outputs, a monitor checks them.
module tb_spi_fsm;
    import spi_fsm_pkg::*;

    logic s_clk = 1'b0;
    logic rst_n;
    logic CS;
    logic read_write;
    logic miso_buff;
    logic ad_we;
    logic sr_we;
    logic dm_we;

    typedef struct {
        logic [3:0] outs;
        int         edge_num;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;

    spi_fsm dut (
        .s_clk      (s_clk),
        .rst_n      (rst_n),
        .CS         (CS),
        .read_write (read_write),
        .miso_buff  (miso_buff),
        .ad_we      (ad_we),
        .sr_we      (sr_we),
        .dm_we      (dm_we)
    );

    always #5 s_clk = ~s_clk;

    function automatic logic [3:0] outs_now();
        return {miso_buff, ad_we, sr_we, dm_we};
    endfunction

    // Expected {miso_buff, ad_we, sr_we, dm_we} seen at edge k of a transaction (edge 1 = first CS-low edge).
    function automatic logic [3:0] tbl(input logic rw, input int k);
        if (rw) return {(k >= 13 && k <= 20), (k == 10), (k == 12), 1'b0};
        return {1'b0, (k == 10), 1'b0, (k == 19)};
    endfunction

    task automatic check_val(input string name, input int edge_num, input logic [3:0] act,
                             input logic [3:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s edge %0d: got %b, expected %b", name, edge_num, act, exp);
    endtask

    // Monitor: mid low phase, after the stimulus has queued the expectation for this cycle.
    initial begin
        forever begin
            @(negedge s_clk);
            #2;
            while (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                check_val(e.tag, e.edge_num, outs_now(), e.outs);
            end
        end
    end

    task automatic step(input logic cs_v, input logic rw_v, input logic [3:0] exp,
                        input int k, input string tag);
        @(negedge s_clk);
        #1;
        CS         = cs_v;
        read_write = rw_v;
        sb.push_back('{exp, k, tag});
        @(posedge s_clk);
    endtask

    task automatic run_txn(input logic rw, input int n, input string tag);
        for (int k = 1; k <= n; k++) step(1'b0, rw, tbl(rw, k), k, tag);
    endtask

    task automatic finish_txn(input logic rw, input int n, input string tag);
        step(1'b1, rw, tbl(rw, n + 1), n + 1, tag);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int k = 0; k < n; k++) step(1'b1, 1'b0, 4'b0000, 0, tag);
    endtask

    // Async reset asserted between edges: outputs, state and count must clear immediately.
    task automatic reset_mid(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check_val({tag, "_outs"}, 0, outs_now(), 4'b0000);
        check_val({tag, "_state"}, 0, 4'(dut.state), 4'(IDLE));
        check_val({tag, "_count"}, 0, 4'(dut.count), 4'd0);
        @(negedge s_clk);
        #1;
        CS = 1'b1;
        @(posedge s_clk);
        @(negedge s_clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        CS         = 1'b1;
        read_write = 1'b0;
        #12;
        check_val("reset_outs", 0, outs_now(), 4'b0000);
        check_val("reset_state", 0, 4'(dut.state), 4'(IDLE));
        check_val("reset_count", 0, 4'(dut.count), 4'd0);
        @(negedge s_clk);
        #1;
        rst_n = 1'b1;

        idle_cycles(2, "idle");
        run_txn(1'b1, 24, "read");
        finish_txn(1'b1, 24, "read_end");
        run_txn(1'b0, 22, "write");
        finish_txn(1'b0, 22, "write_end");

        run_txn(1'b0, 5, "abort_get");
        finish_txn(1'b0, 5, "abort_get");
        idle_cycles(1, "abort_get_idle");
        run_txn(1'b0, 22, "restart_write");
        finish_txn(1'b0, 22, "restart_write");

        run_txn(1'b1, 10, "abort_read1");
        finish_txn(1'b1, 10, "abort_read1");
        idle_cycles(2, "abort_read1_idle");
        run_txn(1'b0, 17, "abort_write1");
        finish_txn(1'b0, 17, "abort_write1");
        idle_cycles(2, "abort_write1_idle");

        run_txn(1'b1, 40, "done_hold");
        finish_txn(1'b1, 40, "done_hold");

        run_txn(1'b1, 20, "b2b_read");
        finish_txn(1'b1, 20, "b2b_read");
        run_txn(1'b0, 19, "b2b_write");
        finish_txn(1'b0, 19, "b2b_write");
        idle_cycles(1, "b2b_idle");

        run_txn(1'b1, 5, "pre_reset_get");
        reset_mid("reset_get");
        idle_cycles(1, "post_reset_get");
        run_txn(1'b1, 15, "pre_reset_read3");
        reset_mid("reset_read3");
        idle_cycles(1, "post_reset_read3");
        run_txn(1'b1, 21, "post_reset_read");
        finish_txn(1'b1, 21, "post_reset_read");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge s_clk);
        #3;
        if (sb.size() > 0) begin
            checks++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
